// File: rtl/data_arbiter_pkg.sv
// Shared types and helpers for the data memory port arbiter.
// Lane-enable and write-data replication rules live here so every user agrees on them.
package data_arbiter_pkg;

    typedef enum logic [1:0] {
        BYTE      = 2'b00,
        HALF_WORD = 2'b01,
        WORD      = 2'b10
    } width_t;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        STORE = 2'd1,
        EXT   = 2'd2
    } requester_t;

    localparam int MEM_LATENCY = 1;

    function automatic logic [3:0] lane_enables(input logic [1:0] width, input logic [1:0] offset);
        case (width)
            BYTE:      lane_enables = 4'b0001 << offset;
            HALF_WORD: lane_enables = 4'b0011 << {offset[1], 1'b0};
            WORD:      lane_enables = 4'b1111;
            default:   lane_enables = 4'b0000;
        endcase
    endfunction

    // Data is replicated rather than shifted; the lane enables pick the bytes.
    function automatic logic [31:0] replicate_data(input logic [1:0] width, input logic [31:0] data);
        case (width)
            BYTE:      replicate_data = {4{data[7:0]}};
            HALF_WORD: replicate_data = {2{data[15:0]}};
            default:   replicate_data = data;
        endcase
    endfunction

    function automatic logic [1:0] next_requester(input logic [1:0] r);
        next_requester = (r == EXT) ? LOAD : r + 2'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter with a forced-grant override.
// An overridden cycle leaves the pointer alone so the displaced requester keeps its turn.
module rr_arbiter3
    import data_arbiter_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [2:0] req_i,
    input  logic       override_i,
    input  logic [2:0] override_grant_i,
    output logic [2:0] grant_o
);

    logic [1:0] ptr_reg;
    logic [1:0] ptr_next;
    logic [2:0] rr_grant;
    logic [1:0] rr_winner;
    logic       found;
    logic [1:0] idx;

    always_comb begin
        rr_grant  = '0;
        rr_winner = ptr_reg;
        found     = 1'b0;
        idx       = ptr_reg;
        for (int k = 0; k < 3; k++) begin
            if (!found && req_i[idx]) begin
                found         = 1'b1;
                rr_grant[idx] = 1'b1;
                rr_winner     = idx;
            end
            idx = next_requester(idx);
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (!override_i && found) begin
            ptr_next = next_requester(rr_winner);
        end
    end

    assign grant_o = override_i ? override_grant_i : rr_grant;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_reg <= LOAD;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/data_port_arbiter.sv
// Shares one single-port data memory between CPU load, CPU store and an external master.
// CPU pulses are held in pending slots; one grant per cycle, responses one cycle later.
module data_port_arbiter
    import data_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 12
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      ld_request_i,
    input  logic [ADDR_WIDTH-1:0]     ld_address_i,
    output logic                      ld_valid_o,
    output logic [31:0]               ld_data_o,
    input  logic                      st_request_i,
    input  logic [ADDR_WIDTH-1:0]     st_address_i,
    input  logic [31:0]               st_data_i,
    input  logic [1:0]                st_width_i,
    output logic                      st_done_o,
    input  logic                      ext_request_i,
    input  logic                      ext_write_i,
    input  logic [ADDR_WIDTH-1:0]     ext_address_i,
    input  logic [31:0]               ext_data_i,
    output logic                      ext_grant_o,
    output logic                      ext_valid_o,
    output logic [31:0]               ext_data_o,
    output logic                      mem_enable_o,
    output logic                      mem_write_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_address_o,
    output logic [3:0]                mem_byte_en_o,
    output logic [31:0]               mem_data_o,
    input  logic [31:0]               mem_data_i
);

    logic                  ld_pend_reg;
    logic [ADDR_WIDTH-1:0] ld_addr_reg;
    logic                  st_pend_reg;
    logic [ADDR_WIDTH-1:0] st_addr_reg;
    logic [31:0]           st_data_reg;
    logic [1:0]            st_width_reg;

    logic                  resp_valid_reg;
    logic [1:0]            resp_owner_reg;
    logic                  resp_write_reg;
    logic [31:0]           ld_data_reg;
    logic [31:0]           ext_data_reg;

    logic                  ld_active;
    logic                  st_active;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic [ADDR_WIDTH-1:0] st_addr;
    logic [31:0]           st_data;
    logic [1:0]            st_width;
    logic                  hazard;
    logic [2:0]            req;
    logic [2:0]            grant;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [1:0]            grant_owner;
    logic                  unused_addr_bits;

    // A pending slot takes precedence over a same-cycle pulse, which is then dropped.
    assign ld_active = ld_pend_reg | ld_request_i;
    assign st_active = st_pend_reg | st_request_i;
    assign ld_addr   = ld_pend_reg ? ld_addr_reg  : ld_address_i;
    assign st_addr   = st_pend_reg ? st_addr_reg  : st_address_i;
    assign st_data   = st_pend_reg ? st_data_reg  : st_data_i;
    assign st_width  = st_pend_reg ? st_width_reg : st_width_i;

    assign hazard = ld_active && st_active
                 && (ld_addr[ADDR_WIDTH-1:2] == st_addr[ADDR_WIDTH-1:2]) && !rst_i;
    assign req    = {ext_request_i, st_active, ld_active} & {3{~rst_i}};

    rr_arbiter3 u_rr (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .req_i            (req),
        .override_i       (hazard),
        .override_grant_i (3'b010),
        .grant_o          (grant)
    );

    always_comb begin
        sel_addr      = ld_addr;
        mem_write_o   = 1'b0;
        mem_byte_en_o = 4'b0000;
        mem_data_o    = 32'h0;
        grant_owner   = LOAD;
        if (grant[STORE]) begin
            sel_addr      = st_addr;
            mem_write_o   = 1'b1;
            mem_byte_en_o = lane_enables(st_width, st_addr[1:0]);
            mem_data_o    = replicate_data(st_width, st_data);
            grant_owner   = STORE;
        end else if (grant[EXT]) begin
            sel_addr      = ext_address_i;
            mem_write_o   = ext_write_i;
            mem_byte_en_o = 4'b1111;
            mem_data_o    = ext_write_i ? ext_data_i : 32'h0;
            grant_owner   = EXT;
        end else if (grant[LOAD]) begin
            mem_byte_en_o = 4'b1111;
        end
    end

    assign mem_enable_o     = |grant;
    assign ext_grant_o      = grant[EXT];
    assign mem_address_o    = {sel_addr[MEM_ADDR_WIDTH-1:2], 2'b00};
    assign unused_addr_bits = ^sel_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ld_pend_reg  <= 1'b0;
            ld_addr_reg  <= '0;
            st_pend_reg  <= 1'b0;
            st_addr_reg  <= '0;
            st_data_reg  <= '0;
            st_width_reg <= '0;
        end else begin
            if (grant[LOAD]) begin
                ld_pend_reg <= 1'b0;
            end else if (ld_request_i && !ld_pend_reg) begin
                ld_pend_reg <= 1'b1;
                ld_addr_reg <= ld_address_i;
            end
            if (grant[STORE]) begin
                st_pend_reg <= 1'b0;
            end else if (st_request_i && !st_pend_reg) begin
                st_pend_reg  <= 1'b1;
                st_addr_reg  <= st_address_i;
                st_data_reg  <= st_data_i;
                st_width_reg <= st_width_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resp_valid_reg <= 1'b0;
            resp_owner_reg <= LOAD;
            resp_write_reg <= 1'b0;
            ld_data_reg    <= '0;
            ext_data_reg   <= '0;
        end else begin
            resp_valid_reg <= |grant;
            resp_owner_reg <= grant_owner;
            resp_write_reg <= mem_write_o;
            if (ld_valid_o) begin
                ld_data_reg <= mem_data_i;
            end
            if (ext_valid_o && !resp_write_reg) begin
                ext_data_reg <= mem_data_i;
            end
        end
    end

    assign ld_valid_o  = resp_valid_reg && (resp_owner_reg == LOAD) && !resp_write_reg;
    assign st_done_o   = resp_valid_reg && (resp_owner_reg == STORE);
    assign ext_valid_o = resp_valid_reg && (resp_owner_reg == EXT);
    assign ld_data_o   = ld_valid_o ? mem_data_i : ld_data_reg;
    assign ext_data_o  = (ext_valid_o && !resp_write_reg) ? mem_data_i : ext_data_reg;

    ld_no_repulse: assert property (@(posedge clk_i) disable iff (rst_i)
        !(ld_request_i && ld_pend_reg));
    st_no_repulse: assert property (@(posedge clk_i) disable iff (rst_i)
        !(st_request_i && st_pend_reg));
    st_width_legal: assert property (@(posedge clk_i) disable iff (rst_i)
        !(grant[STORE] && (st_width == 2'b11)));

endmodule

// File: tb/tb_data_port_arbiter.sv
// Directed bench for data_port_arbiter with a simple word memory behind the port.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_data_port_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ld_request_i;
    logic [31:0] ld_address_i;
    logic        ld_valid_o;
    logic [31:0] ld_data_o;
    logic        st_request_i;
    logic [31:0] st_address_i;
    logic [31:0] st_data_i;
    logic [1:0]  st_width_i;
    logic        st_done_o;
    logic        ext_request_i;
    logic        ext_write_i;
    logic [31:0] ext_address_i;
    logic [31:0] ext_data_i;
    logic        ext_grant_o;
    logic        ext_valid_o;
    logic [31:0] ext_data_o;
    logic        mem_enable_o;
    logic        mem_write_o;
    logic [11:0] mem_address_o;
    logic [3:0]  mem_byte_en_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i;

    logic [31:0] mem [0:1023];
    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    data_port_arbiter #(.ADDR_WIDTH(32), .MEM_ADDR_WIDTH(12)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .ld_request_i  (ld_request_i),
        .ld_address_i  (ld_address_i),
        .ld_valid_o    (ld_valid_o),
        .ld_data_o     (ld_data_o),
        .st_request_i  (st_request_i),
        .st_address_i  (st_address_i),
        .st_data_i     (st_data_i),
        .st_width_i    (st_width_i),
        .st_done_o     (st_done_o),
        .ext_request_i (ext_request_i),
        .ext_write_i   (ext_write_i),
        .ext_address_i (ext_address_i),
        .ext_data_i    (ext_data_i),
        .ext_grant_o   (ext_grant_o),
        .ext_valid_o   (ext_valid_o),
        .ext_data_o    (ext_data_o),
        .mem_enable_o  (mem_enable_o),
        .mem_write_o   (mem_write_o),
        .mem_address_o (mem_address_o),
        .mem_byte_en_o (mem_byte_en_o),
        .mem_data_o    (mem_data_o),
        .mem_data_i    (mem_data_i)
    );

    // Memory model: one-cycle read latency, byte-lane writes.
    always @(posedge clk_i) begin
        if (mem_enable_o) begin
            if (mem_write_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_byte_en_o[b]) mem[mem_address_o[11:2]][b*8 +: 8] <= mem_data_o[b*8 +: 8];
                end
            end else begin
                mem_data_i <= mem[mem_address_o[11:2]];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_i);
    endtask

    task automatic idle();
        ld_request_i  = 1'b0;
        st_request_i  = 1'b0;
        ext_request_i = 1'b0;
        ext_write_i   = 1'b0;
    endtask

    int gap, max_gap, age, max_age, n_valid;
    logic waiting;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem_data_i = 32'h0;
        rst_i = 1'b1;
        idle();
        ld_address_i = 32'h100; st_address_i = 32'h0; st_data_i = 32'h0; st_width_i = 2'b10;
        ext_address_i = 32'h0; ext_data_i = 32'h0;

        // Reset with a request present: everything stays quiet
        ld_request_i = 1'b1; ext_request_i = 1'b1;
        smp();
        check("rst_mem_en", {31'b0, mem_enable_o}, 32'd0);
        check("rst_ext_grant", {31'b0, ext_grant_o}, 32'd0);
        check("rst_ld_valid", {31'b0, ld_valid_o}, 32'd0);
        check("rst_ld_data", ld_data_o, 32'h0);
        cyc(); idle();
        cyc(); rst_i = 1'b0;
        smp();
        check("rel_mem_en", {31'b0, mem_enable_o}, 32'd0);
        check("rel_st_done", {31'b0, st_done_o}, 32'd0);

        // Uncontended word store then load
        cyc(); st_request_i = 1'b1; st_address_i = 32'h100; st_data_i = 32'hDEADBEEF; st_width_i = 2'b10;
        smp();
        check("st_en", {31'b0, mem_enable_o}, 32'd1);
        check("st_wr", {31'b0, mem_write_o}, 32'd1);
        check("st_be", {28'b0, mem_byte_en_o}, 32'hF);
        check("st_addr", {20'b0, mem_address_o}, 32'h100);
        check("st_data", mem_data_o, 32'hDEADBEEF);
        cyc(); idle();
        smp();
        check("st_done", {31'b0, st_done_o}, 32'd1);
        check("st_idle_en", {31'b0, mem_enable_o}, 32'd0);
        cyc();
        smp();
        check("st_done_pulse", {31'b0, st_done_o}, 32'd0);
        cyc(); ld_request_i = 1'b1; ld_address_i = 32'h100;
        smp();
        check("ld_en", {31'b0, mem_enable_o}, 32'd1);
        check("ld_wr", {31'b0, mem_write_o}, 32'd0);
        check("ld_addr", {20'b0, mem_address_o}, 32'h100);
        cyc(); idle();
        smp();
        check("ld_valid", {31'b0, ld_valid_o}, 32'd1);
        check("ld_data", ld_data_o, 32'hDEADBEEF);
        cyc();
        smp();
        check("ld_valid_pulse", {31'b0, ld_valid_o}, 32'd0);
        check("ld_data_hold", ld_data_o, 32'hDEADBEEF);

        // Width lanes
        cyc(); st_request_i = 1'b1; st_address_i = 32'h103; st_data_i = 32'h000000AB; st_width_i = 2'b00;
        smp();
        check("byte_be", {28'b0, mem_byte_en_o}, 32'h8);
        check("byte_data", mem_data_o, 32'hABABABAB);
        check("byte_addr", {20'b0, mem_address_o}, 32'h100);
        cyc(); idle();
        smp();
        check("byte_done", {31'b0, st_done_o}, 32'd1);
        cyc(); st_request_i = 1'b1; st_address_i = 32'h102; st_data_i = 32'h00001234; st_width_i = 2'b01;
        smp();
        check("half_be", {28'b0, mem_byte_en_o}, 32'hC);
        check("half_data", mem_data_o, 32'h12341234);
        cyc(); idle();
        smp();
        check("half_done", {31'b0, st_done_o}, 32'd1);

        // External read sees the merged word
        cyc(); ext_request_i = 1'b1; ext_write_i = 1'b0; ext_address_i = 32'h100;
        smp();
        check("ext_grant", {31'b0, ext_grant_o}, 32'd1);
        check("ext_rd_wr", {31'b0, mem_write_o}, 32'd0);
        cyc(); idle();
        smp();
        check("ext_valid", {31'b0, ext_valid_o}, 32'd1);
        check("ext_data", ext_data_o, 32'h1234BEEF);
        check("ext_grant_off", {31'b0, ext_grant_o}, 32'd0);

        // Three-way contention from pointer LOAD
        cyc();
        ld_request_i = 1'b1; ld_address_i = 32'h300;
        st_request_i = 1'b1; st_address_i = 32'h400; st_data_i = 32'h11112222; st_width_i = 2'b10;
        ext_request_i = 1'b1; ext_write_i = 1'b1; ext_address_i = 32'h500; ext_data_i = 32'hCAFEF00D;
        smp();
        check("c0_addr", {20'b0, mem_address_o}, 32'h300);
        check("c0_wr", {31'b0, mem_write_o}, 32'd0);
        check("c0_ext_grant", {31'b0, ext_grant_o}, 32'd0);
        cyc(); ld_request_i = 1'b0; st_request_i = 1'b0;
        smp();
        check("c1_addr", {20'b0, mem_address_o}, 32'h400);
        check("c1_data", mem_data_o, 32'h11112222);
        check("c1_ld_valid", {31'b0, ld_valid_o}, 32'd1);
        check("c1_ld_data", ld_data_o, 32'h0);
        check("c1_ext_grant", {31'b0, ext_grant_o}, 32'd0);
        cyc();
        smp();
        check("c2_ext_grant", {31'b0, ext_grant_o}, 32'd1);
        check("c2_addr", {20'b0, mem_address_o}, 32'h500);
        check("c2_data", mem_data_o, 32'hCAFEF00D);
        check("c2_st_done", {31'b0, st_done_o}, 32'd1);
        cyc(); idle();
        smp();
        check("c3_ext_valid", {31'b0, ext_valid_o}, 32'd1);
        check("c3_ext_data_hold", ext_data_o, 32'h1234BEEF);
        check("c3_mem_en", {31'b0, mem_enable_o}, 32'd0);

        // Same-word hazard: store first despite pointer LOAD
        cyc();
        st_request_i = 1'b1; st_address_i = 32'h200; st_data_i = 32'h00000055; st_width_i = 2'b00;
        ld_request_i = 1'b1; ld_address_i = 32'h200;
        smp();
        check("hz_wr", {31'b0, mem_write_o}, 32'd1);
        check("hz_be", {28'b0, mem_byte_en_o}, 32'h1);
        check("hz_data", mem_data_o, 32'h55555555);
        cyc(); idle();
        smp();
        check("hz_ld_en", {31'b0, mem_enable_o & ~mem_write_o}, 32'd1);
        check("hz_ld_addr", {20'b0, mem_address_o}, 32'h200);
        check("hz_st_done", {31'b0, st_done_o}, 32'd1);
        cyc();
        smp();
        check("hz_ld_valid", {31'b0, ld_valid_o}, 32'd1);
        check("hz_ld_data", ld_data_o, 32'h00000055);

        // Fairness: EXT held, loads pulse every other cycle
        gap = 0; max_gap = 0; age = 0; max_age = 0; n_valid = 0; waiting = 1'b0;
        cyc();
        for (int i = 0; i < 16; i++) begin
            ld_request_i  = (i < 12) && (i % 2 == 0);
            ld_address_i  = 32'h100;
            ext_request_i = (i < 12);
            ext_write_i   = 1'b0;
            ext_address_i = 32'h100;
            if (ld_request_i) begin
                waiting = 1'b1;
                age = 0;
            end
            smp();
            if (ld_valid_o) n_valid++;
            if (ext_grant_o) gap = 0;
            else if (mem_enable_o) begin
                gap++;
                if (gap > max_gap) max_gap = gap;
            end
            if (waiting) begin
                if (mem_enable_o && !mem_write_o && !ext_grant_o) begin
                    waiting = 1'b0;
                    if (age > max_age) max_age = age;
                end else begin
                    age++;
                end
            end
            cyc();
        end
        idle();
        check("fair_ext_gap", (max_gap <= 1) ? 32'd1 : 32'd0, 32'd1);
        check("fair_ld_wait", (max_age <= 1) ? 32'd1 : 32'd0, 32'd1);
        check("fair_ld_served", {31'b0, waiting}, 32'd0);
        check("fair_ld_count", n_valid, 32'd6);

        // Reset the cycle after a load grant
        ld_request_i = 1'b1; ld_address_i = 32'h100;
        smp();
        check("mr_ld_grant", {31'b0, mem_enable_o}, 32'd1);
        cyc(); idle(); rst_i = 1'b1;
        ld_request_i = 1'b1; ext_request_i = 1'b1;
        smp();
        check("mr_ld_valid", {31'b0, ld_valid_o}, 32'd0);
        check("mr_mem_en", {31'b0, mem_enable_o}, 32'd0);
        check("mr_ext_grant", {31'b0, ext_grant_o}, 32'd0);
        check("mr_ld_data", ld_data_o, 32'h0);
        cyc(); idle();
        cyc(); rst_i = 1'b0;
        smp();
        check("mr_rel_en", {31'b0, mem_enable_o}, 32'd0);
        check("mr_rel_valid", {31'b0, ld_valid_o}, 32'd0);
        cyc(); ld_request_i = 1'b1; ld_address_i = 32'h100;
        smp();
        check("mr_post_en", {31'b0, mem_enable_o}, 32'd1);
        cyc(); idle();
        smp();
        check("mr_post_valid", {31'b0, ld_valid_o}, 32'd1);
        check("mr_post_data", ld_data_o, 32'h1234BEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
